// File: rtl/packet_serializer.sv
// packet_serializer: frames a header byte plus PAYLOAD_BYTES payload bytes
// and shifts the frame out MSB-first, one bit per clock.
module packet_serializer #(
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter logic [7:0]  HEADER_A      = 8'hA5,
  parameter logic [7:0]  HEADER_B      = 8'hC3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hdr_sel,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       serial_out,
  output logic       serial_en,
  output logic       byte_done,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 8;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(7);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(PAYLOAD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_LOAD    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   sh_q, sh_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;

  logic data_ready_q, data_ready_d;
  logic serial_out_q, serial_out_d;
  logic serial_en_q, serial_en_d;
  logic byte_done_q, byte_done_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state and datapath: bit_cnt holds at 7 until the next byte load.
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d       = hdr_sel ? HEADER_B : HEADER_A;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        sh_d = {sh_q[BYTE_W-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          state_d = S_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_LOAD: begin
        if (data_valid) begin
          sh_d       = data_in;
          bit_cnt_d  = '0;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        sh_d = {sh_q[BYTE_W-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          state_d = (byte_cnt_q == LAST_BYTE) ? S_DONE : S_LOAD;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flops are loaded from the next-state view so they line up with state_q.
  always_comb begin
    serial_en_d  = (state_d == S_HEADER) || (state_d == S_PAYLOAD);
    serial_out_d = serial_en_d & sh_d[BYTE_W-1];
    byte_done_d  = serial_en_d & (bit_cnt_d == LAST_BIT);
    data_ready_d = (state_d == S_LOAD);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      data_ready_q <= 1'b0;
      serial_out_q <= 1'b0;
      serial_en_q  <= 1'b0;
      byte_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      data_ready_q <= data_ready_d;
      serial_out_q <= serial_out_d;
      serial_en_q  <= serial_en_d;
      byte_done_q  <= byte_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign serial_out = serial_out_q;
  assign serial_en  = serial_en_q;
  assign byte_done  = byte_done_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_packet_serializer.sv
// Scoreboard bench: unit 0 uses PAYLOAD_BYTES=4, unit 1 uses PAYLOAD_BYTES=1.
module tb_packet_serializer;

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       hs;
    logic       valid;
    logic [7:0] data;
  } in_t;

  typedef struct packed {
    logic ready;
    logic sout;
    logic sen;
    logic bd;
    logic busy;
    logic done;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  drv0, drv1;
  out_t act0, act1;
  logic r0, so0, se0, bd0, bz0, dn0;
  logic r1, so1, se1, bd1, bz1, dn1;

  packet_serializer #(.PAYLOAD_BYTES(4)) dut0 (
    .clk(clk), .reset(drv0.rst), .start(drv0.start), .hdr_sel(drv0.hs),
    .data_in(drv0.data), .data_valid(drv0.valid), .data_ready(r0),
    .serial_out(so0), .serial_en(se0), .byte_done(bd0), .busy(bz0), .done(dn0)
  );

  packet_serializer #(.PAYLOAD_BYTES(1)) dut1 (
    .clk(clk), .reset(drv1.rst), .start(drv1.start), .hdr_sel(drv1.hs),
    .data_in(drv1.data), .data_valid(drv1.valid), .data_ready(r1),
    .serial_out(so1), .serial_en(se1), .byte_done(bd1), .busy(bz1), .done(dn1)
  );

  assign act0 = '{ready: r0, sout: so0, sen: se0, bd: bd0, busy: bz0, done: dn0};
  assign act1 = '{ready: r1, sout: so1, sen: se1, bd: bd1, busy: bz1, done: dn1};

  // Scoreboard queues: per-cycle expected outputs and expected serialized bytes.
  out_t       eq0[$], eq1[$];
  logic [7:0] bq0[$], bq1[$];

  in_t        ci[2];
  out_t       ce[2];
  logic [7:0] pb[2];
  bit         pbv[2];
  int         npk[2];
  int         nhdr[2];
  bit         first[2];
  logic [7:0] asm_b[2];
  bit         started = 1'b0;
  int         total = 0;
  int         bad = 0;

  // Apply one cycle of stimulus and record what the DUTs must show in it.
  task automatic step();
    drv0 = ci[0];
    drv1 = ci[1];
    eq0.push_back(ce[0]);
    eq1.push_back(ce[1]);
    if (pbv[0]) bq0.push_back(pb[0]);
    if (pbv[1]) bq1.push_back(pb[1]);
    started = 1'b1;
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      ci[u]  = '0;
      ce[u]  = '0;
      pbv[u] = 1'b0;
    end
  endtask

  task automatic noise(int u);
    ci[u].start = ($urandom_range(0, 3) == 0);
    ci[u].hs    = 1'($urandom_range(0, 1));
    ci[u].valid = 1'($urandom_range(0, 1));
    ci[u].data  = 8'($urandom);
  endtask

  function automatic out_t bitv(logic [7:0] v, int i);
    out_t o;
    o      = '0;
    o.sout = v[3'(7 - i)];
    o.sen  = 1'b1;
    o.bd   = (i == 7);
    o.busy = 1'b1;
    return o;
  endfunction

  // Reference model: a packet is header + p bytes; each byte is preceded by
  // (stall + 1) ready cycles, then 8 bit cycles; a single done cycle ends it.
  task automatic send_pkt(int u, int p, bit hs, bit directed, int stall0, bit abort);
    logic [7:0] hdr;
    logic [7:0] b;
    int         s;
    hdr = hs ? 8'hC3 : 8'hA5;
    ci[u].start = 1'b1;
    ci[u].hs    = hs;
    ci[u].valid = 1'($urandom_range(0, 1));
    ci[u].data  = 8'($urandom);
    step();
    npk[u]++;
    for (int i = 0; i < 8; i++) begin
      noise(u);
      ce[u] = bitv(hdr, i);
      if (i == 7) begin pb[u] = hdr; pbv[u] = 1'b1; end
      step();
    end
    for (int k = 0; k < p; k++) begin
      b = directed ? 8'(k + 1) : 8'($urandom);
      s = (stall0 >= 0) ? ((k == 0) ? stall0 : 0) : int'($urandom_range(0, 3));
      for (int j = 0; j < s; j++) begin
        noise(u);
        ci[u].valid = 1'b0;
        ce[u].ready = 1'b1;
        ce[u].busy  = 1'b1;
        step();
      end
      noise(u);
      ci[u].valid = 1'b1;
      ci[u].data  = b;
      ce[u].ready = 1'b1;
      ce[u].busy  = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
        noise(u);
        ce[u] = bitv(b, i);
        if (abort && k == 0 && i == 2) begin
          ci[u].rst = 1'b1;
          step();
          return;
        end
        if (i == 7) begin pb[u] = b; pbv[u] = 1'b1; end
        step();
      end
    end
    noise(u);
    ci[u].start = 1'b1;
    ce[u].busy  = 1'b1;
    ce[u].done  = 1'b1;
    step();
  endtask

  // Monitor: compare each cycle, reassemble bytes and detect headers.
  task automatic chk(int u, out_t a);
    out_t       e;
    logic [7:0] eb;
    bit         have;
    total++;
    have = (u == 0) ? (eq0.size() != 0) : (eq1.size() != 0);
    if (!have) begin
      bad++;
      $display("FAIL u%0d cycle-queue empty at %0t, got %b", u, $time, a);
      return;
    end
    if (u == 0) e = eq0.pop_front(); else e = eq1.pop_front();
    if (a !== e) begin
      bad++;
      $display("FAIL u%0d outputs at %0t {ready,sout,sen,bd,busy,done}: got %b want %b",
               u, $time, a, e);
    end
    if (a.sen === 1'b1) asm_b[u] = {asm_b[u][6:0], a.sout};
    if (a.bd === 1'b1) begin
      total++;
      have = (u == 0) ? (bq0.size() != 0) : (bq1.size() != 0);
      if (!have) begin
        bad++;
        $display("FAIL u%0d unexpected byte %h at %0t", u, asm_b[u], $time);
      end else begin
        if (u == 0) eb = bq0.pop_front(); else eb = bq1.pop_front();
        if (asm_b[u] !== eb) begin
          bad++;
          $display("FAIL u%0d byte at %0t: got %h want %h", u, $time, asm_b[u], eb);
        end
      end
      if (first[u] && (asm_b[u] == 8'hA5 || asm_b[u] == 8'hC3)) nhdr[u]++;
      first[u] = 1'b0;
    end
    if (a.busy !== 1'b1) first[u] = 1'b1;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk(0, act0);
      chk(1, act1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drv0 = '0; drv0.rst = 1'b1;
    drv1 = '0; drv1.rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      ci[u] = '0; ce[u] = '0; pbv[u] = 1'b0; pb[u] = '0;
      npk[u] = 0; nhdr[u] = 0; first[u] = 1'b1; asm_b[u] = '0;
    end
    @(posedge clk);
    #1;
    repeat (2) begin
      ci[0].rst = 1'b1;
      ci[1].rst = 1'b1;
      step();
    end
    step();
    send_pkt(0, 4, 1'b0, 1'b1, 0, 1'b0);
    step();
    step();
    send_pkt(0, 4, 1'b1, 1'b0, 5, 1'b0);
    send_pkt(0, 4, 1'b0, 1'b0, -1, 1'b0);
    send_pkt(0, 4, 1'b1, 1'b0, -1, 1'b1);
    send_pkt(0, 4, 1'b0, 1'b0, -1, 1'b0);
    send_pkt(1, 1, 1'b0, 1'b1, 0, 1'b0);
    step();
    send_pkt(1, 1, 1'b1, 1'b0, -1, 1'b0);
    send_pkt(1, 1, 1'b1, 1'b0, 3, 1'b1);
    send_pkt(1, 1, 1'b0, 1'b0, 0, 1'b0);
    repeat (24) begin
      int u;
      u = int'($urandom_range(0, 1));
      send_pkt(u, (u == 0) ? 4 : 1, 1'($urandom_range(0, 1)), 1'b0, -1,
               ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();
    for (int u = 0; u < 2; u++) begin
      total++;
      if (nhdr[u] != npk[u]) begin
        bad++;
        $display("FAIL u%0d header count: got %0d want %0d", u, nhdr[u], npk[u]);
      end
    end
    total++;
    if (bq0.size() != 0 || bq1.size() != 0) begin
      bad++;
      $display("FAIL bytes never serialized: got %0d/%0d left want 0/0", bq0.size(), bq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
- Transmit-side counterpart of the receive path's header detection.
- Frames a packet as one header byte (0xA5 or 0xC3) followed by PAYLOAD_BYTES payload bytes.
- Serializes the frame MSB-first, one bit per clock, with a per-byte completion strobe.
- Payload bytes arrive from upstream logic over a valid/ready handshake; the serial output feeds the link that the receiver's byte assembler and header detector consume.

Parameters:
PAYLOAD_BYTES, 4, payload bytes sent after the header (1..255)
HEADER_A, 8'hA5, header byte sent when hdr_sel=0
HEADER_B, 8'hC3, header byte sent when hdr_sel=1

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a packet; sampled only in IDLE
hdr_sel  input  1  header select, sampled with start (0=HEADER_A, 1=HEADER_B)
data_in  input  8  payload byte, captured on the handshake
data_valid  input  1  upstream has a byte on data_in
data_ready  output  1  block accepts a byte this cycle
serial_out  output  1  current serial bit, MSB first
serial_en  output  1  serial_out carries a valid frame bit
byte_done  output  1  high during the 8th bit of any byte (header or payload)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse after the last payload bit

Behaviour:
- Reset: all outputs are 0 on the cycle after reset is sampled high; the state is IDLE.
- Reset mid-packet aborts immediately and discards the shift register, bit counter and byte counter. No done pulse is issued.
- Datapath: 8-bit shift register sh, 3-bit bit_cnt, 8-bit byte_cnt.
- serial_out = sh[7] whenever serial_en=1; it is 0 otherwise.
- serial_en = 1 in HEADER and PAYLOAD only.
- byte_done = serial_en & (bit_cnt==7).
- States and transitions:
  - IDLE: data_ready=0. If start=1, load sh with HEADER_A or HEADER_B per hdr_sel, clear bit_cnt and byte_cnt, and go to HEADER. start and hdr_sel are ignored in every other state.
  - HEADER: each cycle shift sh left by 1 and increment bit_cnt. When bit_cnt==7, go to LOAD.
  - LOAD: data_ready=1, serial_en=0.
    - If data_valid=1: load sh with data_in, clear bit_cnt, increment byte_cnt, go to PAYLOAD.
    - Otherwise stay in LOAD indefinitely (stall); serial_en stays 0 and the link idles.
  - PAYLOAD: shift as in HEADER.
    - When bit_cnt==7 and byte_cnt==PAYLOAD_BYTES, go to DONE.
    - When bit_cnt==7 otherwise, go to LOAD.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Handshake: a transfer occurs only when data_valid & data_ready in the same cycle. data_in is ignored at all other times. data_valid asserted outside LOAD is held off with no side effects.
- Latency with start in cycle 0 and data_valid held high:
  - Header bits: cycles 1–8.
  - Each payload byte: 1 LOAD cycle + 8 bit cycles.
  - done: cycle 9 + 9*PAYLOAD_BYTES (cycle 45 for the default).
- Back-to-back packets: start may be asserted in the cycle after done, when the state is IDLE. A start that coincides with done is ignored.
- byte_cnt never exceeds PAYLOAD_BYTES; bit_cnt wraps 7→0 only on a byte load.

Test Plan:
- Reset then start=1, hdr_sel=0, data_valid=1 with bytes 0x01,0x02,0x03,0x04 -> serial stream over cycles 1–8 is 1,0,1,0,0,1,0,1. byte_done in cycles 8,17,26,35,44; data_ready in cycles 9,18,27,36; done only in cycle 45. Collected bytes equal A5,01,02,03,04.
- hdr_sel=1 -> first 8 bits are 1,1,0,0,0,0,1,1 (0xC3). Loop the stream into the receive byte assembler plus header detection and confirm the header is flagged exactly once per packet.
- data_valid low for 5 cycles after the header -> data_ready stays high and serial_en stays low for 5 cycles. The next byte goes out intact; done is delayed by exactly 5 cycles (cycle 50).
- start pulsed in mid-payload with hdr_sel toggled -> no effect on the stream or counters. A start in the cycle after done begins a new header one cycle later.
- reset asserted during the 3rd payload bit -> next cycle all outputs 0, no done pulse. A following start sends a full fresh packet with the header first.
- PAYLOAD_BYTES=1 -> exactly 16 serial_en cycles (cycles 1–8 and 10–17), one data_ready handshake, done in cycle 18.
